// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter.
// Holds the FSM state encoding, the default parameter values and the
// helper that sizes the owner/pointer index.
package dff_bank_arbiter_pkg;

   localparam int NREQ_DEFAULT      = 4;
   localparam int WIDTH_DEFAULT     = 8;
   localparam int MAX_BURST_DEFAULT = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   // Index width for NREQ requesters; kept at least 1 bit so a
   // single-requester build still has a legal owner port.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dff_bank_arbiter_flop.sv
// Single-bit storage cell for the register bank.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset, clears the bit
//   d_i    next value
//   q_o    stored value
module dff_bank_arbiter_flop (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) q_o <= 1'b0;
      else       q_o <= d_i;
   end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to a shared
// WIDTH-bit register bank, with a burst limit that forces rotation when
// others are waiting.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset
//   req_i    per-requester level request
//   we_i     per-requester write enable (only the owner's bit matters)
//   wdata_i  packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt_o    registered one-hot grant, zero when idle
//   owner_o  index of grant holder, zero when idle
//   busy_o   high while a grant is active
//   q_o      register bank contents
//
// state    | meaning
// ST_IDLE  | no grant; waiting for any request
// ST_GRANT | one requester owns the bank; burst counter running
module dff_bank_arbiter
   import dff_bank_arbiter_pkg::*;
#(
   parameter  int NREQ      = NREQ_DEFAULT,
   parameter  int WIDTH     = WIDTH_DEFAULT,
   parameter  int MAX_BURST = MAX_BURST_DEFAULT,
   localparam int IDXW      = idx_w(NREQ)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ-1:0]       we_i,
   input  logic [NREQ*WIDTH-1:0] wdata_i,
   output logic [NREQ-1:0]       gnt_o,
   output logic [IDXW-1:0]       owner_o,
   output logic                  busy_o,
   output logic [WIDTH-1:0]      q_o
);

   localparam int BW = $clog2(MAX_BURST + 1);

   state_e            state_q;
   logic [NREQ-1:0]   gnt_q;
   logic [IDXW-1:0]   owner_q;
   logic [IDXW-1:0]   ptr_q;
   logic [BW-1:0]     burst_q;
   logic              busy_q;

   logic [NREQ-1:0]   cand;
   logic              found_d;
   logic [IDXW-1:0]   win_d;
   logic [IDXW-1:0]   ptr_d;
   logic              release_d;

   // While granted, the owner is excluded so a release hands over to
   // someone else; ptr already points past the owner anyway.
   assign cand = (state_q == ST_GRANT) ? (req_i & ~gnt_q) : req_i;

   always_comb begin
      found_d = 1'b0;
      win_d   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found_d && cand[(int'(ptr_q) + k) % NREQ]) begin
            found_d = 1'b1;
            win_d   = IDXW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   assign ptr_d     = IDXW'((int'(win_d) + 1) % NREQ);
   assign release_d = !req_i[owner_q] ||
                      ((burst_q == BW'(MAX_BURST)) && found_d);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         burst_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (found_d) begin
                  state_q <= ST_GRANT;
                  gnt_q   <= NREQ'(1) << win_d;
                  owner_q <= win_d;
                  ptr_q   <= ptr_d;
                  burst_q <= BW'(1);
                  busy_q  <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (release_d && found_d) begin
                  gnt_q   <= NREQ'(1) << win_d;
                  owner_q <= win_d;
                  ptr_q   <= ptr_d;
                  burst_q <= BW'(1);
               end else if (release_d) begin
                  state_q <= ST_IDLE;
                  gnt_q   <= '0;
                  owner_q <= '0;
                  burst_q <= '0;
                  busy_q  <= 1'b0;
               end else if (burst_q != BW'(MAX_BURST)) begin
                  burst_q <= burst_q + BW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Bank write: gnt is one-hot, so the owner's slice is the only candidate.
   logic             wr_en;
   logic [WIDTH-1:0] wr_slice;
   logic [WIDTH-1:0] bank_d;
   logic [WIDTH-1:0] bank_q;

   assign wr_en    = |(gnt_q & req_i & we_i);
   assign wr_slice = wdata_i[int'(owner_q)*WIDTH +: WIDTH];
   assign bank_d   = wr_en ? wr_slice : bank_q;

   for (genvar b = 0; b < WIDTH; b++) begin : g_bank
      dff_bank_arbiter_flop u_flop (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .d_i   (bank_d[b]),
         .q_o   (bank_q[b])
      );
   end

   assign gnt_o   = gnt_q;
   assign owner_o = owner_q;
   assign busy_o  = busy_q;
   assign q_o     = bank_q;

endmodule

// File: doc/dff_bank_arbiter.md
DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the register bank.
REQ-002 Parameter WIDTH, default 8: register bank width in bits.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive granted cycles before forced rotation when others are waiting.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester access request, level-sensitive.
REQ-007 we  input  NREQ  per-requester write enable; meaningful only while granted.
REQ-008 wdata  input  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 gnt  output  NREQ  registered one-hot grant; all-zero when idle.
REQ-010 owner  output  clog2(NREQ)  index of the current grant holder; 0 when idle.
REQ-011 busy  output  1  high while any grant is active.
REQ-012 q  output  WIDTH  current register bank contents.

Function
REQ-013 The state machine SHALL have two states, IDLE and GRANT.
REQ-014 In IDLE with req nonzero at edge N, gnt SHALL be one-hot, with busy=1, from edge N; the first grant appears one cycle after the request is sampled.
REQ-015 Winner selection SHALL be round-robin: search req starting from the pointer ptr, upward modulo NREQ, and take the first set bit.
REQ-016 On each new grant to requester i, ptr SHALL become (i+1) mod NREQ.
REQ-017 q SHALL load wdata slice i at an edge only when gnt[i], req[i] and we[i] are all high at that edge; otherwise q holds.
REQ-018 Granted cycles in which we[i] is low SHALL leave q unchanged and still count toward the burst.
REQ-019 The burst counter SHALL reset to 1 on each new grant and increment on each further granted cycle.
REQ-020 The grant SHALL release when req[owner] is low, or when the counter equals MAX_BURST and any other req bit is high.
REQ-021 On release with other requests pending, the next winner SHALL be granted at the same edge, with no idle gap; gnt switches directly.
REQ-022 On release with no other requests pending, the FSM SHALL return to IDLE, with gnt=0 and busy=0 from that edge.
REQ-023 If the counter reaches MAX_BURST and no other request is pending, the owner SHALL keep the grant and the counter SHALL saturate at MAX_BURST.
REQ-024 A requester dropping req in the same cycle it would write SHALL NOT write.
REQ-025 Bits of we for non-granted requesters SHALL be ignored.
REQ-026 gnt SHALL never have more than one bit set.

Reset
REQ-027 While rst is high at an edge, the block SHALL set: state=IDLE, gnt=0, owner=0, busy=0, q=0, ptr=0, burst counter=0.
REQ-028 Reset asserted mid-burst SHALL override all requests and writes at that edge.
REQ-029 Arbitration after reset SHALL start from requester 0.

Structure
REQ-030 The state encoding, the clog2-based index width and the default parameter values SHALL live in a shared package.
REQ-031 The register bank SHALL be built from WIDTH instances of the existing flipflop cell, with a write-enable mux in front of each d input; this is the only sub-module.
REQ-032 The round-robin search SHALL be combinational and the grant registered; no combinational path from req to gnt.

Verification
REQ-033 Single requester: req=0001, we=0001, wdata slice0=8'hA5 -> gnt=0001 one cycle later, and q=8'hA5 after the next edge.
REQ-034 Contention: req=1111 held, we=1111, MAX_BURST=4 -> grants of 4 cycles each, order 0,1,2,3,0, with no gap cycles between owners.
REQ-035 Early release: requester 2 holds a grant, then drops req after 2 cycles while req[1] is high -> gnt=0010 at that edge, and ptr moves to 2.
REQ-036 Burst saturation: only req[3] high for 10 cycles -> gnt=1000 throughout, and q tracks wdata slice3 every cycle we[3]=1.
REQ-037 Reset mid-burst: rst=1 during a requester-1 grant with q=8'h3C -> the next edge gives gnt=0, busy=0, q=0; with req=1111 after reset, requester 0 is granted first.
REQ-038 Non-granted write: requester 0 granted, we=0100 with slice2=8'hFF -> q is unchanged.
